host_spi_master: RTL
====================

Name: host_spi_master

Overview:
- Host-side SPI initiator: the far end of the device's SPI slave host interface.
- Pops bytes from an 8-bit first-word-fall-through (FWFT) TX FIFO and shifts them out on mosi, MSB first, in SPI mode 0 (sck idle low).
- Captures miso into bytes and writes them to an RX FIFO.
- Used on the companion/bench FPGA and in system simulation to drive the device's SPI slave; sample edge selectable to match the slave's miso_edge setting.

Parameters:
- CLK_DIV, 4: sck half-period in clk cycles; legal range 2..255.
- SS_SETUP, 2: clk cycles from ss_n falling to the start of the first sck low phase.
- SS_HOLD, 2: clk cycles from the last sck falling edge to ss_n rising.
- SS_IDLE, 4: minimum clk cycles ss_n stays high between frames.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  permits new frames; does not abort a frame in progress.
- miso_edge  in  1  0 = sample miso on sck rising edge; 1 = sample on sck falling edge.
- tx_fifo_rd_en  out  1  one-cycle pop strobe to the TX FIFO.
- tx_fifo_din  in  8  TX FIFO head data (FWFT, valid while !tx_fifo_empty).
- tx_fifo_empty  in  1  TX FIFO empty.
- rx_wr_en  out  1  one-cycle write strobe to the RX FIFO.
- rx_data  out  8  received byte; valid while rx_wr_en is high, held otherwise.
- rx_full  in  1  RX FIFO full.
- ss_n  out  1  slave select, active low.
- sck  out  1  serial clock.
- mosi  out  1  master out.
- miso  in  1  master in; already synchronised externally.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: ss_n=1, sck=0, mosi=0, tx_fifo_rd_en=0, rx_wr_en=0, rx_data=0, busy=0; FSM returns to IDLE.
- Reset mid-frame: all outputs return to their reset values on the next clk edge. No rx_wr_en is issued for the partial byte. The IDLE minimum-gap counter starts fresh.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - Start condition: en && !tx_fifo_empty && !rx_full.
  - On start: pulse tx_fifo_rd_en, load tx_fifo_din into the shift register, go to SETUP.
  - Next cycle: ss_n=0 and mosi=din[7].
- SETUP: hold for SS_SETUP cycles with sck=0, then go to SHIFT.
- SHIFT: 8 bit-periods. Each bit-period is sck low for CLK_DIV cycles, then sck high for CLK_DIV cycles.
  - mosi changes only on sck falling edges (and at byte load); the next bit is driven at the falling edge ending each bit-period.
  - miso is registered on the clk edge at which the sck register changes to the level selected by miso_edge. MSB is received first.
  - 3-bit bit counter; the divider counter reloads at each sck toggle.
- Byte boundary (the falling edge ending bit-period 8):
  - rx_data is updated and rx_wr_en pulses in the next cycle.
  - If en && !tx_fifo_empty && !rx_full: pop the next byte in that same cycle, drive mosi = new bit7, stay in SHIFT. Back-to-back bytes have no extra gap; ss_n stays low.
  - Otherwise go to HOLD.
- HOLD: sck=0 for SS_HOLD cycles, then ss_n=1 and go to GAP.
- GAP: ss_n=1 for SS_IDLE cycles, then go to IDLE.
- Reference timing: first sck rising edge occurs SS_SETUP+CLK_DIV cycles after ss_n falls. One byte lasts 16*CLK_DIV cycles.
- RX space: rx_full is checked only when a byte starts. This block is the sole writer of the RX FIFO, so a free slot is guaranteed when rx_wr_en fires. rx_wr_en is never asserted while rx_full is high at byte start.
- tx_fifo_rd_en is never asserted while tx_fifo_empty=1.
- en falling mid-frame: the current byte completes, then the frame ends through HOLD.
- sck never glitches: every high and low phase is exactly CLK_DIV cycles.

Decomposition:
- Shared header (define.v style): FSM state encodings HSM_IDLE..HSM_GAP and the default CLK_DIV/SS_* values, shared with the bench models.
- One natural sub-module, host_spi_master_sckgen: divider counter producing the sck level plus one-cycle rise_stb/fall_stb strobes, with a run/clear input.
- FSM, bit counter and shift registers stay in the top module.

Test Plan:
- Single byte, default parameters, miso_edge=0; TX FIFO holds 0xA5; slave model returns 0x3C.
  -> ss_n low 2+4*16+2=68 cycles; mosi sequence 1,0,1,0,0,1,0,1; exactly 8 sck rising edges; one rx_wr_en with rx_data=0x3C; busy drops after GAP.
- Burst of 0x01, 0x80, 0xFF with miso looped to mosi.
  -> single ss_n low window; 24 sck pulses; no gap between bytes; RX receives 0x01, 0x80, 0xFF in order.
- miso_edge=1, slave changes miso on rising edges, returns 0x5A.
  -> rx_data=0x5A; repeating with miso_edge=0 against the same slave yields a one-bit-skewed value, confirming the edge selection.
- rx_full asserted during byte 1 of a 2-byte burst.
  -> byte 1 completes and is written; frame ends through HOLD; byte 2 is not popped until rx_full=0; new frame starts only after SS_IDLE cycles.
- reset pulsed at bit 4 of 0xC3.
  -> next cycle ss_n=1, sck=0, mosi=0, busy=0; no rx_wr_en; a following byte 0x12 transfers correctly.
- en=0 with TX FIFO non-empty.
  -> no pop, ss_n stays 1. en rises -> frame starts with ss_n low on the cycle after the pop.

Source files
------------

// File: rtl/host_spi_master_pkg.sv
// host_spi_master_pkg: shared FSM state encoding and default timing values for host_spi_master.
package host_spi_master_pkg;
    typedef enum logic [2:0] {
        HSM_IDLE,
        HSM_SETUP,
        HSM_SHIFT,
        HSM_HOLD,
        HSM_GAP
    } hsm_state_e;

    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_SS_SETUP = 2;
    localparam int unsigned DEF_SS_HOLD  = 2;
    localparam int unsigned DEF_SS_IDLE  = 4;
endpackage

// File: rtl/host_spi_master_if.sv
// host_spi_master_if: FIFO handshakes, SPI pins and status of the host SPI initiator.
//   en, miso_edge          : frame permit and miso sample-edge select
//   tx_fifo_*              : FWFT TX FIFO pop strobe, head data, empty flag
//   rx_wr_en, rx_data      : RX FIFO write strobe and byte; rx_full = RX FIFO full
//   ss_n, sck, mosi, miso  : SPI mode-0 pins
//   busy                   : initiator not idle
interface host_spi_master_if;
    logic       en;
    logic       miso_edge;
    logic       tx_fifo_rd_en;
    logic [7:0] tx_fifo_din;
    logic       tx_fifo_empty;
    logic       rx_wr_en;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       ss_n;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       busy;

    modport master (
        input  en, miso_edge, tx_fifo_din, tx_fifo_empty, rx_full, miso,
        output tx_fifo_rd_en, rx_wr_en, rx_data, ss_n, sck, mosi, busy
    );

    modport slave (
        output en, miso_edge, tx_fifo_din, tx_fifo_empty, rx_full, miso,
        input  tx_fifo_rd_en, rx_wr_en, rx_data, ss_n, sck, mosi, busy
    );
endinterface

// File: rtl/host_spi_master_sckgen.sv
// host_spi_master_sckgen: sck divider; toggles sck every CLK_DIV cycles while run_i is high.
//   clk, reset  : clock and synchronous active-high reset
//   run_i       : 1 = count and toggle, 0 = hold sck low with the divider cleared
//   sck_o       : registered sck level
//   rise_stb_o  : high in the cycle whose closing edge drives sck high
//   fall_stb_o  : high in the cycle whose closing edge drives sck low
module host_spi_master_sckgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    output logic sck_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);
    logic [7:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    logic       tick;

    always_comb begin
        tick  = run_i && (cnt_q == 8'(CLK_DIV - 1));
        cnt_d = (!run_i || tick) ? 8'd0 : cnt_q + 8'd1;
        sck_d = run_i && (tick ? !sck_q : sck_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o      = sck_q;
    assign rise_stb_o = tick && !sck_q;
    assign fall_stb_o = tick && sck_q;
endmodule

// File: rtl/host_spi_master.sv
// host_spi_master: SPI mode-0 initiator moving bytes from a FWFT TX FIFO out on mosi and miso into an RX FIFO.
//   clk, reset : clock and synchronous active-high reset
//   bus        : host_spi_master_if.master (FIFO handshakes, SPI pins, busy)
module host_spi_master
    import host_spi_master_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned SS_SETUP = DEF_SS_SETUP,
    parameter int unsigned SS_HOLD  = DEF_SS_HOLD,
    parameter int unsigned SS_IDLE  = DEF_SS_IDLE
) (
    input  logic                  clk,
    input  logic                  reset,
    host_spi_master_if.master     bus
);
    hsm_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_wr_en_q, rx_wr_en_d;
    logic       ss_n_q, ss_n_d;
    logic       rd_en;
    logic       start, cap, last_fall;
    logic [7:0] rx_next;
    logic       sck, rise_stb, fall_stb;

    host_spi_master_sckgen #(.CLK_DIV(CLK_DIV)) u_sckgen (
        .clk       (clk),
        .reset     (reset),
        .run_i     (state_q == HSM_SHIFT),
        .sck_o     (sck),
        .rise_stb_o(rise_stb),
        .fall_stb_o(fall_stb)
    );

    always_comb begin
        start     = bus.en && !bus.tx_fifo_empty && !bus.rx_full;
        cap       = bus.miso_edge ? fall_stb : rise_stb;
        last_fall = fall_stb && (bit_q == 3'd7);
        rx_next   = {rx_sh_q[6:0], bus.miso};
        state_d    = state_q;
        cnt_d      = cnt_q + 8'd1;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = cap ? rx_next : rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_wr_en_d = 1'b0;
        ss_n_d     = ss_n_q;
        rd_en      = 1'b0;
        case (state_q)
            HSM_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    rd_en   = 1'b1;
                    tx_sh_d = bus.tx_fifo_din;
                    ss_n_d  = 1'b0;
                    state_d = HSM_SETUP;
                end
            end
            HSM_SETUP: begin
                if (cnt_q == 8'(SS_SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = HSM_SHIFT;
                end
            end
            HSM_SHIFT: begin
                cnt_d = '0;
                if (fall_stb) begin
                    bit_d   = bit_q + 3'd1;
                    tx_sh_d = {tx_sh_q[6:0], 1'b0};
                end
                if (last_fall) begin
                    // With falling-edge sampling the last bit is captured on this very edge.
                    rx_data_d  = bus.miso_edge ? rx_next : rx_sh_q;
                    rx_wr_en_d = 1'b1;
                    if (start) begin
                        rd_en   = 1'b1;
                        tx_sh_d = bus.tx_fifo_din;
                    end else begin
                        state_d = HSM_HOLD;
                    end
                end
            end
            HSM_HOLD: begin
                if (cnt_q == 8'(SS_HOLD - 1)) begin
                    cnt_d   = '0;
                    ss_n_d  = 1'b1;
                    state_d = HSM_GAP;
                end
            end
            HSM_GAP: begin
                if (cnt_q == 8'(SS_IDLE - 1)) begin
                    cnt_d   = '0;
                    state_d = HSM_IDLE;
                end
            end
            default: state_d = HSM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HSM_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_wr_en_q <= 1'b0;
            ss_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_wr_en_q <= rx_wr_en_d;
            ss_n_q     <= ss_n_d;
        end
    end

    // The pop strobe is combinational, so it is masked while reset is held.
    assign bus.tx_fifo_rd_en = rd_en && !reset;
    assign bus.rx_wr_en      = rx_wr_en_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.ss_n          = ss_n_q;
    assign bus.sck           = sck;
    assign bus.mosi          = tx_sh_q[7];
    assign bus.busy          = (state_q != HSM_IDLE);
endmodule
